// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues one imem read per cycle while space remains and
// buffers {pc, instruction} pairs in a circular FIFO presented to decode.
module fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        pc_advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        decode_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = CW + 1;

  typedef enum logic {FS_IDLE, FS_WAIT} fstate_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     inflight_pc_q, inflight_pc_d;
  fstate_e         state_q;
  logic            push, pop, issue;
  logic [OW-1:0]   occ_after;

  // Handshakes: the outstanding read counts against capacity so a response always has room.
  always_comb begin
    instr_valid = (count_q != '0) && !redirect;
    pop         = instr_valid && decode_ready;
    push        = (state_q == FS_WAIT) && !redirect;
    occ_after   = OW'(count_q) + OW'(state_q == FS_WAIT) - OW'(pop);
    issue       = !rst && !redirect && (occ_after < OW'(DEPTH));
    imem_req    = issue;
    pc_advance  = issue;
    imem_addr   = pc;
    instr       = mem_q[rd_ptr_q].word;
    instr_pc    = mem_q[rd_ptr_q].pc;
  end

  // Pointer, occupancy and in-flight pc next state; redirect flushes everything.
  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    inflight_pc_d = inflight_pc_q;
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = PW'(wr_ptr_q + 1'b1);
      if (pop)  rd_ptr_d = PW'(rd_ptr_q + 1'b1);
      count_d = CW'(count_q + CW'(push) - CW'(pop));
    end
    if (issue) inflight_pc_d = pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      inflight_pc_q <= '0;
      state_q       <= FS_IDLE;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      inflight_pc_q <= inflight_pc_d;
      state_q       <= issue ? FS_WAIT : FS_IDLE;
    end
  end

  // Data storage needs no reset; contents are only observed behind instr_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: inflight_pc_q, word: imem_rdata};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based reference of the fetch path.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        decode_ready;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .pc_advance   (pc_advance),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .decode_ready (decode_ready)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] mq [$];
  bit          m_out;
  logic [31:0] m_out_pc;
  logic [31:0] rdata_nx;
  logic        seen_valid;
  logic [31:0] seen_pc;
  logic        seen_adv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the reference, advance both.
  task automatic cycle(input logic r, input logic rd, input logic dr, input logic [31:0] tgt);
    logic        ev, ep, ei;
    logic [63:0] head;
    logic [31:0] pc_nx;
    @(negedge clk);
    rst          = r;
    redirect     = rd;
    decode_ready = dr;
    imem_rdata   = rdata_nx;
    #1;
    ev = !r && !rd && (mq.size() != 0);
    ep = ev && dr;
    ei = !r && !rd && ((mq.size() + int'(m_out) - int'(ep)) < int'(DEPTH));
    seen_valid = instr_valid;
    seen_pc    = instr_pc;
    seen_adv   = pc_advance;
    chk("instr_valid", 32'(instr_valid), 32'(ev));
    chk("imem_req", 32'(imem_req), 32'(ei));
    chk("pc_advance", 32'(pc_advance), 32'(ei));
    if (ev) begin
      head = mq[0];
      chk("instr_pc", instr_pc, head[63:32]);
      chk("instr", instr, head[31:0]);
    end
    if (ei) chk("imem_addr", imem_addr, pc);
    if (r || rd) begin
      mq.delete();
      m_out = 1'b0;
    end else begin
      if (ep) void'(mq.pop_front());
      if (m_out) mq.push_back({m_out_pc, imem_rdata});
      m_out    = ei;
      m_out_pc = pc;
    end
    rdata_nx = ei ? (pc ^ 32'hA5A5_0000) : $urandom;
    pc_nx    = rd ? tgt : (ei ? pc + 32'd4 : pc);
    @(posedge clk);
    #1;
    pc = pc_nx;
  endtask

  initial begin
    int          first;
    int          issues;
    logic [31:0] redir_pc;
    logic        r, rd, dr;
    rst = 1'b1; redirect = 1'b0; decode_ready = 1'b0;
    pc = '0; imem_rdata = '0; rdata_nx = '0; m_out = 1'b0; m_out_pc = '0;

    repeat (2) cycle(1'b1, 1'b0, 1'b1, 32'h0);

    // Streaming from pc 0: first instruction visible two cycles after release.
    first = -1;
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 32'h0);
      if (first < 0 && seen_valid) first = k;
    end
    chk("first_valid_cycle", 32'(first), 32'd2);

    // Backpressure from empty: exactly DEPTH issues, pc stalls at 0x10.
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    pc = 32'h0;
    issues = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      if (seen_adv) issues++;
    end
    chk("bp_issues", 32'(issues), 32'(DEPTH));
    chk("bp_pc", pc, 32'h10);
    repeat (2) cycle(1'b0, 1'b0, 1'b1, 32'h0);

    // Redirect with a read in flight: next presented pc is the target.
    cycle(1'b0, 1'b1, 1'b1, 32'h100);
    redir_pc = '0;
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 32'h0);
      if (seen_valid) begin
        redir_pc = seen_pc;
        break;
      end
    end
    chk("redirect_first_pc", redir_pc, 32'h100);

    // Fill under backpressure, then reset mid-stream and restart.
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'h0);
    repeat (6) cycle(1'b0, 1'b0, 1'b1, 32'h0);

    for (int k = 0; k < 3000; k++) begin
      r  = ($urandom_range(0, 199) == 0);
      rd = ($urandom_range(0, 15) == 0);
      dr = ($urandom_range(0, 3) != 0);
      cycle(r, rd, dr, $urandom & 32'hFFFF_FFFC);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
